// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Valid/ready handshake on both the binary input and the packed BCD output.
module binary_to_bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   bin_q;
    logic [BIN_W-1:0]   bin_next;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_next;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    // Add-3 correction on every digit >= 5, digits adjusted independently
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        bin_next   = bin_q;
        bcd_next   = bcd_q;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    bin_next   = bin_in;
                    bcd_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            bin_q     <= bin_next;
            bcd_q     <= bcd_next;
            cnt       <= cnt_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: vector table, sweep and
// hand-written handshake/reset sequences, all checked through a scoreboard.
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd_out;
    logic        busy;

    binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    typedef struct {
        logic [11:0] bcd;
        int          acc;
    } sb_t;

    sb_t  sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic ov_prev  = 1'b0;
    logic hs_prev  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [11:0] bcd_model(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v)       % 10);
        r[7:4]  = 4'((v / 10)  % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    // Output monitor: latency on out_valid rise, value at handshake, single-cycle handshake
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) chk("out_valid_drop", 32'(out_valid), 32'd0);
            if (out_valid && !ov_prev) begin
                if (sbq.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
                else chk("latency", 32'(cyc - sbq[0].acc), 32'd8);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                    chk("digit_range",
                        32'((bcd_out[3:0] <= 4'd9) && (bcd_out[7:4] <= 4'd9) && (bcd_out[11:8] <= 4'd9)),
                        32'd1);
                end
            end
            ov_prev = out_valid;
            hs_prev = out_valid && out_ready;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("timeout_in_ready", 32'd0, 32'd1);
    endtask

    // Present one word; returns with the accepting edge just behind us
    task automatic send(input logic [7:0] v, input logic [11:0] exp, output int acc);
        sb_t e;
        wait_ready();
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk); #1;
        acc   = cyc;
        e.bcd = exp;
        e.acc = acc;
        sbq.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) chk("timeout_drain", 32'(sbq.size()), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        int acc;
        int acc2;
        int n;

        tbl[0] = '{8'd0,   12'h000};
        tbl[1] = '{8'd255, 12'h255};
        tbl[2] = '{8'd99,  12'h099};
        tbl[3] = '{8'd1,   12'h001};
        tbl[4] = '{8'd9,   12'h009};
        tbl[5] = '{8'd10,  12'h010};
        tbl[6] = '{8'd100, 12'h100};
        tbl[7] = '{8'd199, 12'h199};

        rst       = 1'b1;
        in_valid  = 1'b0;
        bin_in    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_bcd_out",   32'(bcd_out),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].bin, tbl[i].bcd, acc);
            drain();
        end

        // Full sweep against the reference model
        for (int v = 0; v < 256; v++) begin
            send(8'(v), bcd_model(v), acc);
            drain();
        end

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        send(8'd128, 12'h128, acc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reached_done", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_bcd_out",   32'(bcd_out),   32'h128);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // in_valid with changing bin_in during SHIFT is ignored
        send(8'd173, 12'h173, acc);
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bin_in = 8'($urandom_range(0, 255));
            chk("shift_in_ready", 32'(in_ready), 32'd0);
            chk("shift_busy",     32'(busy),     32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Asynchronous reset after four iterations aborts the conversion
        send(8'd200, 12'h200, acc);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_bcd_out",   32'(bcd_out),   32'd0);
        sbq.delete();
        #1;
        rst = 1'b0;
        send(8'd42, 12'h042, acc);
        drain();

        // Back-to-back words with in_valid and out_ready held high
        begin
            sb_t e;
            in_valid = 1'b1;
            bin_in   = 8'd7;
            @(posedge clk); #1;
            acc   = cyc;
            e.bcd = 12'h007;
            e.acc = acc;
            sbq.push_back(e);
            bin_in = 8'd200;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!in_ready && n < 50);
            @(posedge clk); #1;
            acc2  = cyc;
            e.bcd = 12'h200;
            e.acc = acc2;
            sbq.push_back(e);
            in_valid = 1'b0;
            chk("b2b_spacing", 32'(acc2 - acc), 32'd10);
            drain();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
